// File: rtl/reg_access_pkg.sv
// ============================================================================
// Module      : reg_access_pkg
// Description : Shared FSM state type and slave register addresses for the
//               register-access arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_IDLE = 2'b00;
    localparam logic [1:0] ADDR_REG1 = 2'b01;
    localparam logic [1:0] ADDR_REG2 = 2'b10;
    localparam logic [1:0] ADDR_REG3 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker: first set request at or
//               above the pointer, wrapping. Pointer state lives in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic [PTR_W-1:0] w_sel;
    logic             w_found;

    always_comb begin
        grant_o = '0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sel = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!w_found && req_i[w_sel]) begin
                grant_o[w_sel] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_access_arbiter.sv
// ============================================================================
// Module      : reg_access_arbiter
// Description : Round-robin arbiter sharing one register-slave port between
//               NUM_REQ requesters, one transaction in flight at a time.
//               Optional macro REG_ACCESS_ADDR_CHECK_EN rejects illegal
//               accesses without touching the slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_access_arbiter
    import reg_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ-1:0]            reqWrite,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqWdata,
    output logic [NUM_REQ-1:0]            reqReady,
    output logic [NUM_REQ-1:0]            rspValid,
    output logic [DATA_WIDTH-1:0]         rspData,
    output logic                          rspErr,
    output logic [ADDR_WIDTH-1:0]         writeAddress,
    output logic [DATA_WIDTH-1:0]         writeData,
    input  logic                          writeResponse,
    output logic [ADDR_WIDTH-1:0]         readAddress,
    input  logic [DATA_WIDTH-1:0]         readData
);

    localparam int                    c_ptr_w     = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] c_addr_idle = ADDR_WIDTH'(ADDR_IDLE);

    state_t                  state_q, state_d;
    logic [c_ptr_w-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]      winner_q;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    rsp_err_q;

    logic [NUM_REQ-1:0]      w_grant;
    logic [c_ptr_w-1:0]      w_win_idx;
    logic                    w_any;
    logic                    w_sel_wr;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_legal;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_rr (
        .req_i   (reqValid),
        .ptr_i   (ptr_q),
        .grant_o (w_grant)
    );

    assign w_any = |reqValid;

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_win_idx = c_ptr_w'(i);
            end
        end
    end

    assign w_sel_wr   = reqWrite[w_win_idx];
    assign w_sel_addr = reqAddr[int'(w_win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_data = reqWdata[int'(w_win_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign ptr_d      = (w_win_idx == c_ptr_w'(NUM_REQ - 1)) ? '0
                                                             : w_win_idx + c_ptr_w'(1);

`ifdef REG_ACCESS_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] c_addr_reg1 = ADDR_WIDTH'(ADDR_REG1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_reg2 = ADDR_WIDTH'(ADDR_REG2);
    localparam logic [ADDR_WIDTH-1:0] c_addr_reg3 = ADDR_WIDTH'(ADDR_REG3);

    assign w_legal = w_sel_wr ? ((w_sel_addr == c_addr_reg2) || (w_sel_addr == c_addr_reg3))
                              : (w_sel_addr == c_addr_reg1);
`else
    assign w_legal = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_any) state_d = w_legal ? ISSUE : RESP;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // reqReady is gated by rst so a requester held valid through reset is not accepted early
    always_comb begin
        reqReady     = '0;
        rspValid     = '0;
        writeAddress = c_addr_idle;
        writeData    = '0;
        readAddress  = c_addr_idle;
        case (state_q)
            IDLE: begin
                if (!rst) reqReady = w_grant;
            end
            ISSUE: begin
                if (wr_q) begin
                    writeAddress = addr_q;
                    writeData    = data_q;
                end else begin
                    readAddress  = addr_q;
                end
            end
            RESP:    rspValid = winner_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            winner_q   <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && w_any) begin
                ptr_q    <= ptr_d;
                winner_q <= w_grant;
                wr_q     <= w_sel_wr;
                addr_q   <= w_sel_addr;
                data_q   <= w_sel_data;
                if (!w_legal) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                end
            end
            if (state_q == WAIT) begin
                rsp_data_q <= wr_q ? '0 : readData;
                rsp_err_q  <= wr_q & ~writeResponse;
            end
        end
    end

    assign rspData = rsp_data_q;
    assign rspErr  = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_access_arbiter.sv
// ============================================================================
// Module      : tb_reg_access_arbiter
// Description : Directed, table-driven bench for reg_access_arbiter with a
//               behavioural register slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_access_arbiter;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int NR = 2;
    localparam logic [DW-1:0] REG1_VAL = 32'h12345678;
`ifdef REG_ACCESS_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    reqValid, reqWrite, reqReady, rspValid;
    logic [NR*AW-1:0] reqAddr;
    logic [NR*DW-1:0] reqWdata;
    logic [DW-1:0]    rspData, writeData, readData;
    logic             rspErr, writeResponse;
    logic [AW-1:0]    writeAddress, readAddress;
    logic [DW-1:0]    reg2 = '0;
    logic [DW-1:0]    reg3 = '0;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int            req;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        logic          illegal;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    reg_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqWdata(reqWdata),
        .reqReady(reqReady), .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr),
        .writeAddress(writeAddress), .writeData(writeData), .writeResponse(writeResponse),
        .readAddress(readAddress), .readData(readData)
    );

    // Slave: write response for reg2/reg3 only, registered read data for reg1 only
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            writeResponse <= 1'b0;
            readData      <= '0;
        end else begin
            writeResponse <= (writeAddress == 2'b10) || (writeAddress == 2'b11);
            readData      <= (readAddress == 2'b01) ? REG1_VAL : '0;
        end
    end

    always @(posedge clk) begin
        if (writeAddress == 2'b10) reg2 <= writeData;
        if (writeAddress == 2'b11) reg3 <= writeData;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic start_txn(input int r, input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data);
        int n;
        @(negedge clk);
        reqWrite[r]           = wr;
        reqAddr[r*AW +: AW]   = addr;
        reqWdata[r*DW +: DW]  = data;
        reqValid[r]           = 1'b1;
        #1;
        n = 0;
        while (!reqReady[r] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", 64'(reqReady), 64'(1 << r));
    endtask

    task automatic finish_txn(input int r, input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic [DW-1:0] exp_data,
                              input logic exp_err, input int lat);
        logic [AW-1:0] ewa, era;
        logic [DW-1:0] ewd;
        ewa = '0;
        era = '0;
        ewd = '0;
        if (lat == 3) begin
            if (wr) begin
                ewa = addr;
                ewd = data;
            end else begin
                era = addr;
            end
        end
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) reqValid[r] = 1'b0;
            #1;
            if (c == 1) chk("issue_bus", {writeAddress, readAddress, writeData}, {ewa, era, ewd});
            else        chk("idle_bus", {writeAddress, readAddress, writeData}, '0);
            if (c < lat) begin
                chk("rsp_early", 64'(rspValid), 64'(0));
            end else begin
                chk("rsp_valid", 64'(rspValid), 64'(1 << r));
                chk("rsp_data", rspData, exp_data);
                chk("rsp_err", rspErr, exp_err);
            end
        end
        @(negedge clk);
        #1;
        chk("rsp_hold", {rspValid, rspErr, rspData}, {2'b00, exp_err, exp_data});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ed;
        logic          ee;
        int            lat;
        int            cyc, nacc, cnt0, cnt1;
        int            acc_cyc[8];
        logic [NR-1:0] acc_grant[8];

        vecs[0] = '{0, 1'b1, 2'b10, 32'hDEADBEEF, 32'h0,      1'b0, 1'b0};
        vecs[1] = '{1, 1'b0, 2'b01, 32'h0,        REG1_VAL,   1'b0, 1'b0};
        vecs[2] = '{0, 1'b1, 2'b01, 32'hA5A5A5A5, 32'h0,      1'b1, 1'b1};
        vecs[3] = '{1, 1'b1, 2'b11, 32'hCAFEF00D, 32'h0,      1'b0, 1'b0};
        vecs[4] = '{0, 1'b0, 2'b10, 32'h0,        32'h0,      1'b0, 1'b1};
        vecs[5] = '{1, 1'b0, 2'b00, 32'h0,        32'h0,      1'b0, 1'b1};
        vecs[6] = '{1, 1'b1, 2'b00, 32'h11111111, 32'h0,      1'b1, 1'b1};

        rst      = 1'b1;
        reqValid = '0;
        reqWrite = '0;
        reqAddr  = '0;
        reqWdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctl", {reqReady, rspValid, rspErr, writeAddress, readAddress}, '0);
        chk("reset_data", {rspData, writeData}, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("idle_quiet", {reqReady, rspValid, writeAddress, readAddress, writeData}, '0);
        end
        chk("idle_regs", {reg2, reg3}, '0);

        for (int i = 0; i < 7; i++) begin
            if (CHK && vecs[i].illegal) begin
                ed  = '0;
                ee  = 1'b1;
                lat = 1;
            end else begin
                ed  = vecs[i].exp_data;
                ee  = vecs[i].exp_err;
                lat = 3;
            end
            start_txn(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            finish_txn(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata, ed, ee, lat);
        end
        chk("slave_reg2", reg2, 32'hDEADBEEF);
        chk("slave_reg3", reg3, 32'hCAFEF00D);

        // Reset during WAIT of a write to reg3 while req1 is queued
        start_txn(0, 1'b1, 2'b11, 32'h0BADF00D);
        @(negedge clk);
        reqValid[0]        = 1'b0;
        reqWrite[1]        = 1'b0;
        reqAddr[AW +: AW]  = 2'b01;
        reqValid[1]        = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ctl", {reqReady, rspValid, rspErr, writeAddress, readAddress}, '0);
        chk("midrst_data", {rspData, writeData}, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("midrst_no_rsp", 64'(rspValid), 64'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", 64'(reqReady), 64'(2'b10));
        finish_txn(1, 1'b0, 2'b01, 32'h0, REG1_VAL, 1'b0, 3);

        // Both requesters persistent from reset release, 4 grants each
        @(negedge clk);
        rst      = 1'b1;
        reqWrite = '0;
        reqAddr  = {2'b01, 2'b01};
        reqValid = 2'b11;
        @(negedge clk);
        rst  = 1'b0;
        cyc  = 0;
        nacc = 0;
        cnt0 = 0;
        cnt1 = 0;
        while (nacc < 8 && cyc < 60) begin
            #1;
            if (reqReady != '0) begin
                acc_grant[nacc] = reqReady;
                acc_cyc[nacc]   = cyc;
                nacc++;
                if (reqReady[0]) cnt0++;
                if (reqReady[1]) cnt1++;
            end
            @(negedge clk);
            cyc++;
            if (cnt0 >= 4) reqValid[0] = 1'b0;
            if (cnt1 >= 4) reqValid[1] = 1'b0;
        end
        chk("rr_accepts", 64'(nacc), 64'(8));
        for (int k = 0; k < nacc; k++) begin
            chk("rr_grant", 64'(acc_grant[k]), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            if (k > 0) chk("rr_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(4));
        end
        reqValid = '0;
        repeat (6) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Shares the single register-slave access port between NUM_REQ requesters (e.g. host CPU path and an internal sequencer).
- Round-robin arbitration; one transaction in flight at a time.
- Drives the slave's writeAddress/writeData/readAddress.
- Collects writeResponse/readData and returns a single-cycle response to the granted requester.

Parameters:
- DATA_WIDTH, 32, data width of slave and requester data.
- ADDR_WIDTH, 2, slave register address width.
- NUM_REQ, 2, number of requesters (2..8).

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- reqValid  input  NUM_REQ  per-requester request valid.
- reqWrite  input  NUM_REQ  1 = write, 0 = read.
- reqAddr  input  NUM_REQ*ADDR_WIDTH  flattened request addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- reqWdata  input  NUM_REQ*DATA_WIDTH  flattened write data.
- reqReady  output  NUM_REQ  one-hot accept pulse.
- rspValid  output  NUM_REQ  one-hot response pulse.
- rspData  output  DATA_WIDTH  read data; 0 for writes.
- rspErr  output  1  error flag, valid with rspValid.
- writeAddress  output  ADDR_WIDTH  to slave.
- writeData  output  DATA_WIDTH  to slave.
- writeResponse  input  1  from slave; 1 the cycle after a write to 2'b10/2'b11.
- readAddress  output  ADDR_WIDTH  to slave.
- readData  input  DATA_WIDTH  from slave; registered, valid the cycle after readAddress.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; reqReady, rspValid, rspData, rspErr, writeAddress, writeData, readAddress all 0; round-robin pointer = 0.
- Idle address: writeAddress and readAddress are 2'b00 in every state except ISSUE. The slave decodes writeAddress every cycle, so any other value would cause spurious writes.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any reqValid is set, pick the winner: first set bit searching from the pointer upward, wrapping.
  - Pulse reqReady[winner] for 1 cycle (accept cycle T).
  - Latch write, address and data; go to ISSUE.
  - Pointer = (winner+1) mod NUM_REQ.
- ISSUE (T+1):
  - Write: writeAddress = latched address, writeData = latched data.
  - Read: readAddress = latched address.
  - Held for exactly 1 cycle.
- WAIT (T+2):
  - Write: capture writeResponse; error = ~writeResponse.
  - Read: capture readData; error = 0.
- RESP (T+3): rspValid[winner] = 1 for 1 cycle; rspData = captured read data (0 for writes); rspErr = error.
- Latency: accept-to-response is 3 cycles. Earliest next accept is T+4. Peak throughput is 1 transaction per 4 cycles.
- Request rules:
  - A requester holds reqValid and its payload stable until it sees reqReady.
  - A request that appears while the block is busy waits; it is never dropped.
  - reqValid is ignored outside IDLE.
- Responses have no backpressure; the requester must sample the rspValid cycle.
- Simultaneous requests: only one is granted per IDLE visit. Under persistent requests, every requester is granted within NUM_REQ grants.
- rspData and rspErr hold their last values outside RESP.
- Reset mid-transaction: in-flight transaction abandoned; no rspValid; outputs return to reset values immediately.
- Write to 2'b00/2'b01: issued; slave returns writeResponse = 0, so rspErr = 1.
- Read of an address other than 2'b01: issued; slave returns 0, so rspData = 0 and rspErr = 0.

Optional Feature:
- Macro REG_ACCESS_ADDR_CHECK_EN.
- Defined:
  - Illegal accesses are rejected without touching the slave. Illegal means a write to an address other than 2'b10/2'b11, or a read of an address other than 2'b01.
  - Rejected path: IDLE -> RESP; rspValid at T+1, rspErr = 1, rspData = 0.
  - Legal accesses behave as above.
- Undefined: all accesses are issued; error detection as described in Behaviour.

Decomposition:
- Package reg_access_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - address constants ADDR_IDLE = 2'b00, ADDR_REG1 = 2'b01, ADDR_REG2 = 2'b10, ADDR_REG3 = 2'b11.
- Sub-module rr_arbiter:
  - parameter NUM_REQ; inputs request vector, pointer; output one-hot grant.
  - Purely combinational; pointer register lives in the parent.

Test Plan:
- Req0 writes 2'b10, data 0xDEADBEEF at accept cycle T -> writeAddress = 2'b10 only at T+1; rspValid[0] at T+3; rspErr = 0; rspData = 0; slave reg2 = 0xDEADBEEF.
- Req1 reads 2'b01 with reg1 = 0x12345678 -> readAddress = 2'b01 at T+1; rspValid[1] at T+3; rspData = 0x12345678; rspErr = 0.
- Both requesters hold reqValid from reset release, 4 transactions each -> grants alternate 0,1,0,1...; accepts spaced exactly 4 cycles apart.
- Req0 writes 2'b01, data 0xA5A5A5A5:
  - macro undefined -> rspErr = 1 at T+3; reg2/reg3 unchanged.
  - macro defined -> rspValid at T+1, rspErr = 1; writeAddress stays 2'b00 throughout.
- rst asserted during WAIT of a write to 2'b11 -> no rspValid; all outputs 0 in the same cycle; after release, a pending req1 is granted first (pointer = 0, only req1 valid).
- No requests for 20 cycles -> writeAddress = readAddress = 2'b00 and writeData = 0 every cycle; reg2/reg3 unchanged.
